// File: rtl/cyphertext_bank.sv
// -----------------------------------------------------------------------------
// cyphertext_bank
//
// Indexed store for finished ciphertext words. Each entry has a valid bit.
// Writes arrive one word per finish_i strobe at index pc_i. Every accepted
// write is also echoed on cyphertext_q for one-cycle observation.
// Reads return data, hit and valid one cycle after rd_req_i.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   finish_i           write strobe (one word per high cycle)
//   pc_i               write index
//   cyphertext_i       write data
//   cyphertext_q       registered copy of the last accepted write data
//   echo_valid_o       pulse: cyphertext_q was loaded on the last edge
//   rd_req_i           read request
//   rd_addr_i          read index
//   rd_data_o          read data (0 when the entry is not valid)
//   rd_valid_o         pulse: rd_data_o / rd_hit_o belong to a request
//   rd_hit_o           addressed entry held valid data
//   flush_i            invalidate every entry
//   count_o            number of valid entries
//   full_o, empty_o    count_o == MEMORY_SIZE / count_o == 0 (registered)
//   overwrite_o        pulse: accepted write landed on an already valid entry
//   err_addr_o         pulse: write or read index was out of range
// -----------------------------------------------------------------------------
module cyphertext_bank #(
  parameter int TEXT_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 4,
  parameter int MEMORY_SIZE   = 16,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  finish_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [TEXT_WIDTH-1:0] cyphertext_i,
  output logic [TEXT_WIDTH-1:0] cyphertext_q,
  output logic                  echo_valid_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [TEXT_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_hit_o,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overwrite_o,
  output logic                  err_addr_o
);

  // Index width actually needed to address MEMORY_SIZE entries.
  localparam int IDX_W = $clog2(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] ONE_W  = (ADDR_WIDTH + 1)'(1);

  logic [TEXT_WIDTH-1:0]  mem [MEMORY_SIZE];
  logic [TEXT_WIDTH-1:0]  mem_rd_q;

  logic [MEMORY_SIZE-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   full_q, empty_q;
  logic                   echo_valid_q, overwrite_q, err_addr_q;
  logic                   rd_valid_q, rd_hit_q, rd_bypass_q;

  logic [IDX_W-1:0]       wr_idx, rd_idx;
  logic                   wr_in_range, rd_in_range;
  logic                   wr_acc, rd_acc, bypass, rd_hit_d;
  logic                   wr_new, rd_clr;

  assign wr_idx      = pc_i[IDX_W-1:0];
  assign rd_idx      = rd_addr_i[IDX_W-1:0];
  assign wr_in_range = {1'b0, pc_i} < SIZE_W;
  assign rd_in_range = {1'b0, rd_addr_i} < SIZE_W;

  // A flush discards any write issued in the same cycle.
  assign wr_acc   = finish_i & wr_in_range & ~flush_i;
  assign rd_acc   = rd_req_i & rd_in_range;
  assign bypass   = wr_acc & rd_acc & (wr_idx == rd_idx);
  assign rd_hit_d = rd_acc & (bypass | valid_q[rd_idx]);
  assign wr_new   = wr_acc & ~valid_q[wr_idx];
  // Clear-on-read is applied after the write, so a same-cycle write+read of
  // one index leaves it invalid.
  assign rd_clr   = (CLEAR_ON_READ != 0) & rd_hit_d & ~flush_i;

  for (genvar gi = 0; gi < MEMORY_SIZE; gi++) begin : g_valid
    assign valid_d[gi] = ~flush_i
                       & ~(rd_clr & (rd_idx == IDX_W'(gi)))
                       & (valid_q[gi] | (wr_acc & (wr_idx == IDX_W'(gi))));
  end

  // A new entry and a cleared entry in one cycle cancel, so count_q never
  // leaves 0..MEMORY_SIZE.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({wr_new, rd_clr})
        2'b10:   count_d = count_q + ONE_W;
        2'b01:   count_d = count_q - ONE_W;
        default: count_d = count_q;
      endcase
    end
  end

  // Data array: no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_idx] <= cyphertext_i;
    end
    mem_rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      cyphertext_q <= '0;
      echo_valid_q <= 1'b0;
      overwrite_q  <= 1'b0;
      err_addr_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_bypass_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      full_q       <= (count_d == SIZE_W);
      empty_q      <= (count_d == '0);
      if (wr_acc) begin
        cyphertext_q <= cyphertext_i;
      end
      echo_valid_q <= wr_acc;
      overwrite_q  <= wr_acc & valid_q[wr_idx];
      err_addr_q   <= (finish_i & ~wr_in_range) | (rd_req_i & ~rd_in_range);
      rd_valid_q   <= rd_req_i;
      rd_hit_q     <= rd_hit_d;
      rd_bypass_q  <= bypass;
    end
  end

  // On a bypassed read the write was accepted, so cyphertext_q already holds
  // exactly the word that the RAM read port could not yet see.
  assign rd_data_o    = rd_hit_q ? (rd_bypass_q ? cyphertext_q : mem_rd_q) : '0;
  assign rd_valid_o   = rd_valid_q;
  assign rd_hit_o     = rd_hit_q;
  assign echo_valid_o = echo_valid_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign overwrite_o  = overwrite_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_cyphertext_bank.sv
module tb_cyphertext_bank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         finish = 1'b0;
  logic [4:0]   pc = '0;
  logic [127:0] ct = '0;
  logic         rd_req = 1'b0;
  logic [4:0]   rd_addr = '0;
  logic         flush = 1'b0;

  logic [127:0] cq_a, rd_data_a, cq_b, rd_data_b;
  logic         echo_v_a, rd_valid_a, rd_hit_a, full_a, empty_a, ovw_a, err_a;
  logic         echo_v_b, rd_valid_b, rd_hit_b, full_b, empty_b, ovw_b, err_b;
  logic [5:0]   count_a, count_b;

  // A: plain bank, out-of-range indices reachable. B: clear-on-read variant.
  cyphertext_bank #(.TEXT_WIDTH(128), .ADDR_WIDTH(5), .MEMORY_SIZE(16), .CLEAR_ON_READ(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .finish_i(finish), .pc_i(pc), .cyphertext_i(ct),
    .cyphertext_q(cq_a), .echo_valid_o(echo_v_a), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .rd_hit_o(rd_hit_a), .flush_i(flush),
    .count_o(count_a), .full_o(full_a), .empty_o(empty_a), .overwrite_o(ovw_a), .err_addr_o(err_a));

  cyphertext_bank #(.TEXT_WIDTH(128), .ADDR_WIDTH(5), .MEMORY_SIZE(16), .CLEAR_ON_READ(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .finish_i(finish), .pc_i(pc), .cyphertext_i(ct),
    .cyphertext_q(cq_b), .echo_valid_o(echo_v_b), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .rd_hit_o(rd_hit_b), .flush_i(flush),
    .count_o(count_b), .full_o(full_b), .empty_o(empty_b), .overwrite_o(ovw_b), .err_addr_o(err_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic         hit;
    int           cyc;
  } rd_exp_t;
  rd_exp_t rq[$];
  rd_exp_t mon_e;

  // Reference model of dut_a
  logic [127:0] m_data [16];
  logic [15:0]  m_valid = '0;
  int           m_count = 0;
  logic [127:0] m_echo = '0;
  logic         exp_ovw, exp_err, exp_echo_v;

  // Read-response scoreboard for dut_a, including the one-cycle latency.
  always @(negedge clk) begin
    if (rst_n && rd_valid_a) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected cyc=%0d got data=%h hit=%b want no response", cyc, rd_data_a, rd_hit_a);
      end else begin
        mon_e = rq.pop_front();
        if (rd_data_a !== mon_e.data || rd_hit_a !== mon_e.hit || cyc !== mon_e.cyc) begin
          n_err++;
          $display("FAIL rd_resp got data=%h hit=%b cyc=%0d want data=%h hit=%b cyc=%0d",
                   rd_data_a, rd_hit_a, cyc, mon_e.data, mon_e.hit, mon_e.cyc);
        end
      end
    end
  end

  // Drive one cycle of stimulus, update the model, push read expectations.
  task automatic step(input bit w, input logic [4:0] wpc, input logic [127:0] wd,
                      input bit r, input logic [4:0] ra, input bit fl);
    rd_exp_t e;
    bit w_ok;
    finish = w; pc = wpc; ct = wd; rd_req = r; rd_addr = ra; flush = fl;
    w_ok       = w && (wpc < 5'd16) && !fl;
    exp_err    = (w && wpc >= 5'd16) || (r && ra >= 5'd16);
    exp_ovw    = w_ok && m_valid[wpc[3:0]];
    exp_echo_v = w_ok;
    if (r) begin
      e.cyc = cyc + 1;
      if (ra >= 5'd16) begin
        e.data = '0; e.hit = 1'b0;
      end else if (w_ok && wpc == ra) begin
        e.data = wd; e.hit = 1'b1;
      end else if (m_valid[ra[3:0]]) begin
        e.data = m_data[ra[3:0]]; e.hit = 1'b1;
      end else begin
        e.data = '0; e.hit = 1'b0;
      end
      rq.push_back(e);
    end
    if (fl) begin
      m_valid = '0; m_count = 0;
    end else if (w_ok) begin
      if (!m_valid[wpc[3:0]]) m_count++;
      m_valid[wpc[3:0]] = 1'b1;
      m_data[wpc[3:0]]  = wd;
      m_echo            = wd;
    end
    $display("txn cyc=%0d wr=%b pc=%0d rd=%b ra=%0d flush=%b data=%h", cyc, w, wpc, r, ra, fl, wd);
    @(posedge clk); #1;
    finish = 1'b0; rd_req = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    step(0, 5'd0, '0, 0, 5'd0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count_a !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_a); end
    n_cmp++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty_a, full_a); end
    n_cmp++; if (cq_a !== '0 || rd_data_a !== '0) begin n_err++; $display("FAIL reset_data got cq=%h rd=%h want 0", cq_a, rd_data_a); end
    n_cmp++; if ({echo_v_a, rd_valid_a, rd_hit_a, ovw_a, err_a} !== 5'b0) begin n_err++; $display("FAIL reset_pulses got %b want 00000", {echo_v_a, rd_valid_a, rd_hit_a, ovw_a, err_a}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] v;
    v = 128'h00112233445566778899AABBCCDDEEFF;
    step(1, 5'd3, v, 0, 5'd0, 0);
    n_cmp++; if (cq_a !== v || echo_v_a !== 1'b1) begin n_err++; $display("FAIL basic_echo got cq=%h ev=%b want %h 1", cq_a, echo_v_a, v); end
    n_cmp++; if (count_a !== 6'd1 || empty_a !== 1'b0 || full_a !== 1'b0) begin n_err++; $display("FAIL basic_count got %0d e=%b f=%b want 1 0 0", count_a, empty_a, full_a); end
    n_cmp++; if (ovw_a !== 1'b0) begin n_err++; $display("FAIL basic_ovw got %b want 0", ovw_a); end
    step(0, 5'd0, '0, 1, 5'd3, 0);
    n_cmp++; if (cq_a !== v || echo_v_a !== 1'b0) begin n_err++; $display("FAIL basic_hold got cq=%h ev=%b want %h 0", cq_a, echo_v_a, v); end
    n_cmp++; if (count_a !== 6'd1) begin n_err++; $display("FAIL basic_count_after_read got %0d want 1", count_a); end
    step(0, 5'd0, '0, 1, 5'd4, 0);
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL basic_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_fill_overwrite();
    logic [127:0] nv;
    step(0, 5'd0, '0, 0, 5'd0, 1);
    n_cmp++; if (count_a !== 6'd0 || empty_a !== 1'b1) begin n_err++; $display("FAIL fill_flush got %0d e=%b want 0 1", count_a, empty_a); end
    for (int i = 0; i < 16; i++) begin
      step(1, 5'(i), {$urandom, $urandom, $urandom, $urandom}, 0, 5'd0, 0);
      n_cmp++; if (count_a !== 6'(m_count) || full_a !== (m_count == 16) || ovw_a !== exp_ovw)
        begin n_err++; $display("FAIL fill_%0d got cnt=%0d f=%b o=%b want %0d %b %b", i, count_a, full_a, ovw_a, m_count, m_count == 16, exp_ovw); end
    end
    nv = {$urandom, $urandom, $urandom, $urandom};
    step(1, 5'd5, nv, 0, 5'd0, 0);
    n_cmp++; if (ovw_a !== 1'b1 || count_a !== 6'd16 || full_a !== 1'b1) begin n_err++; $display("FAIL fill_overwrite got o=%b cnt=%0d f=%b want 1 16 1", ovw_a, count_a, full_a); end
    step(0, 5'd0, '0, 1, 5'd5, 0);
    n_cmp++; if (ovw_a !== 1'b0 || full_a !== 1'b1) begin n_err++; $display("FAIL fill_ovw_pulse got o=%b f=%b want 0 1", ovw_a, full_a); end
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL fill_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_err_addr();
    step(1, 5'd20, 128'hDEAD, 0, 5'd0, 0);
    n_cmp++; if (err_a !== 1'b1 || echo_v_a !== 1'b0) begin n_err++; $display("FAIL err_wr got err=%b ev=%b want 1 0", err_a, echo_v_a); end
    n_cmp++; if (count_a !== 6'(m_count) || cq_a !== m_echo) begin n_err++; $display("FAIL err_wr_state got cnt=%0d cq=%h want %0d %h", count_a, cq_a, m_count, m_echo); end
    step(0, 5'd0, '0, 1, 5'd25, 0);
    n_cmp++; if (err_a !== 1'b1) begin n_err++; $display("FAIL err_rd got %b want 1", err_a); end
    idle();
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL err_pulse got %b want 0", err_a); end
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL err_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)), 0);
      n_cmp++; if (count_a !== 6'(m_count) || full_a !== (m_count == 16) || empty_a !== (m_count == 0))
        begin n_err++; $display("FAIL b2b_count_%0d got %0d f=%b e=%b want %0d", i, count_a, full_a, empty_a, m_count); end
      n_cmp++; if (ovw_a !== exp_ovw || err_a !== exp_err || echo_v_a !== exp_echo_v || cq_a !== m_echo)
        begin n_err++; $display("FAIL b2b_pulses_%0d got o=%b e=%b ev=%b cq=%h want %b %b %b %h", i, ovw_a, err_a, echo_v_a, cq_a, exp_ovw, exp_err, exp_echo_v, m_echo); end
    end
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL b2b_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_flush();
    step(0, 5'd0, '0, 0, 5'd0, 1);
    for (int i = 0; i < 4; i++) step(1, 5'(i), {4{32'(i + 32'hA5)}}, 0, 5'd0, 0);
    n_cmp++; if (count_a !== 6'd4) begin n_err++; $display("FAIL flush_pre_count got %0d want 4", count_a); end
    // Flush with a same-cycle write to 9 and read of 1 (pre-flush data).
    step(1, 5'd9, 128'h9999, 1, 5'd1, 1);
    n_cmp++; if (count_a !== 6'd0 || empty_a !== 1'b1 || full_a !== 1'b0) begin n_err++; $display("FAIL flush_count got %0d e=%b f=%b want 0 1 0", count_a, empty_a, full_a); end
    n_cmp++; if (echo_v_a !== 1'b0 || cq_a !== m_echo) begin n_err++; $display("FAIL flush_echo got ev=%b cq=%h want 0 %h", echo_v_a, cq_a, m_echo); end
    step(0, 5'd0, '0, 1, 5'd9, 0);
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL flush_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_clear_on_read();
    logic [127:0] d7, d2;
    d7 = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
    d2 = 128'h2222_ABCD_2222_ABCD_2222_ABCD_2222_ABCD;
    step(0, 5'd0, '0, 0, 5'd0, 1);
    step(1, 5'd7, d7, 1, 5'd7, 0);
    n_cmp++; if (rd_valid_b !== 1'b1 || rd_hit_b !== 1'b1 || rd_data_b !== d7) begin n_err++; $display("FAIL cor_wt got v=%b h=%b d=%h want 1 1 %h", rd_valid_b, rd_hit_b, rd_data_b, d7); end
    n_cmp++; if (count_b !== 6'd0 || empty_b !== 1'b1) begin n_err++; $display("FAIL cor_wt_count got %0d e=%b want 0 1", count_b, empty_b); end
    n_cmp++; if (count_a !== 6'd1) begin n_err++; $display("FAIL cor_plain_count got %0d want 1", count_a); end
    step(0, 5'd0, '0, 1, 5'd7, 0);
    n_cmp++; if (rd_valid_b !== 1'b1 || rd_hit_b !== 1'b0 || rd_data_b !== '0) begin n_err++; $display("FAIL cor_reread got v=%b h=%b d=%h want 1 0 0", rd_valid_b, rd_hit_b, rd_data_b); end
    step(1, 5'd2, d2, 0, 5'd0, 0);
    n_cmp++; if (count_b !== 6'd1) begin n_err++; $display("FAIL cor_wr_count got %0d want 1", count_b); end
    step(0, 5'd0, '0, 1, 5'd2, 0);
    n_cmp++; if (rd_hit_b !== 1'b1 || rd_data_b !== d2 || count_b !== 6'd0) begin n_err++; $display("FAIL cor_clear got h=%b d=%h cnt=%0d want 1 %h 0", rd_hit_b, rd_data_b, count_b, d2); end
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL cor_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_reset_midread();
    logic [127:0] v;
    n_cmp++; if (count_a !== 6'(m_count) || m_count == 0) begin n_err++; $display("FAIL rmr_pre_count got %0d want %0d (nonzero)", count_a, m_count); end
    rd_req = 1'b1; rd_addr = 5'd7;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (count_a !== 6'd0 || empty_a !== 1'b1 || full_a !== 1'b0) begin n_err++; $display("FAIL rmr_count got %0d e=%b f=%b want 0 1 0", count_a, empty_a, full_a); end
    n_cmp++; if (cq_a !== '0 || rd_data_a !== '0 || rd_valid_a !== 1'b0 || echo_v_a !== 1'b0) begin n_err++; $display("FAIL rmr_outputs got cq=%h rd=%h v=%b ev=%b want 0", cq_a, rd_data_a, rd_valid_a, echo_v_a); end
    rd_req = 1'b0;
    m_valid = '0; m_count = 0; m_echo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (rd_valid_a !== 1'b0 || echo_v_a !== 1'b0) begin n_err++; $display("FAIL rmr_no_resp_%0d got v=%b ev=%b want 0 0", i, rd_valid_a, echo_v_a); end
    end
    v = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    step(1, 5'd3, v, 1, 5'd3, 0);
    n_cmp++; if (echo_v_a !== 1'b1 || cq_a !== v || count_a !== 6'd1) begin n_err++; $display("FAIL rmr_first_write got ev=%b cq=%h cnt=%0d want 1 %h 1", echo_v_a, cq_a, count_a, v); end
    idle();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL rmr_pending got %0d want 0", rq.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill_overwrite();
    test_err_addr();
    test_back_to_back();
    test_flush();
    test_clear_on_read();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
